// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared types and constants for the geofence feeder
package geofence_pkg;

    localparam int COORD_W       = 10;
    localparam int PTS_PER_FRAME = 7;
    localparam int IDX_W         = 3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/geofence_frame_buf.sv
// rtl/geofence_frame_buf.sv - two-bank ping-pong store of 7-point frames
module geofence_frame_buf
    import geofence_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_valid_i,
    input  point_t           wr_pt_i,
    output logic             wr_ready_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             rd_release_i,
    output logic             rd_full_o,
    output point_t           rd_pt_o
);

    point_t           mem_q [2][PTS_PER_FRAME];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_fire;
    logic             wr_last;

    assign wr_ready_o = !full_q[wr_bank_q];
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign wr_last    = (wr_idx_q == IDX_W'(PTS_PER_FRAME - 1));
    assign rd_full_o  = full_q[rd_bank_q];
    assign rd_pt_o    = (rd_idx_i < IDX_W'(PTS_PER_FRAME)) ? mem_q[rd_bank_q][rd_idx_i] : '0;

    // Fill and release may hit different banks on the same edge; both apply.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        if (wr_fire) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (rd_release_i) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= wr_pt_i;
        end
    end

endmodule

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - streams buffered frames to a geofence evaluator and reports results
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int WDOG_CYCLES = 512,
    parameter int ID_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               geo_rst,
    output logic [COORD_W-1:0] geo_x,
    output logic [COORD_W-1:0] geo_y,
    input  logic               geo_valid,
    input  logic               geo_inside,
    output logic               res_valid,
    output logic               res_inside,
    output logic               res_err,
    output logic [ID_W-1:0]    res_id
);

    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             geo_rst_q, geo_rst_d;
    point_t           geo_pt_q, geo_pt_d;
    logic             res_valid_q, res_valid_d;
    logic             res_inside_q, res_inside_d;
    logic             res_err_q, res_err_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [ID_W-1:0]  frame_id_q, frame_id_d;

    logic             rd_full;
    logic             rd_release;
    logic [IDX_W-1:0] rd_idx;
    point_t           rd_pt;
    point_t           in_pt;

    assign in_pt.x = in_x;
    assign in_pt.y = in_y;

    geofence_frame_buf u_buf (
        .clk_i        (clk),
        .reset_i      (reset),
        .wr_valid_i   (in_valid),
        .wr_pt_i      (in_pt),
        .wr_ready_o   (in_ready),
        .rd_idx_i     (rd_idx),
        .rd_release_i (rd_release),
        .rd_full_o    (rd_full),
        .rd_pt_o      (rd_pt)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wdog_d       = wdog_q;
        geo_rst_d    = geo_rst_q;
        geo_pt_d     = geo_pt_q;
        res_valid_d  = 1'b0;
        res_inside_d = res_inside_q;
        res_err_d    = res_err_q;
        res_id_d     = res_id_q;
        frame_id_d   = frame_id_q;
        rd_idx       = '0;
        rd_release   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                geo_rst_d = 1'b1;
                if (rd_full) begin
                    geo_pt_d  = rd_pt;
                    geo_rst_d = 1'b0;
                    idx_d     = IDX_W'(1);
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (idx_q == IDX_W'(PTS_PER_FRAME)) begin
                    rd_release = 1'b1;
                    wdog_d     = '0;
                    state_d    = ST_WAIT;
                end else begin
                    rd_idx   = idx_q;
                    geo_pt_d = rd_pt;
                    idx_d    = idx_q + 1'b1;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (geo_valid) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = geo_inside;
                    res_err_d    = 1'b0;
                    res_id_d     = frame_id_q;
                    frame_id_d   = frame_id_q + 1'b1;
                    // After release the read pointer already names the other bank.
                    if (rd_full) begin
                        geo_pt_d = rd_pt;
                        idx_d    = IDX_W'(1);
                        state_d  = ST_STREAM;
                    end else begin
                        geo_rst_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = 1'b0;
                    res_err_d    = 1'b1;
                    res_id_d     = frame_id_q;
                    frame_id_d   = frame_id_q + 1'b1;
                    geo_rst_d    = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                geo_rst_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wdog_q       <= '0;
            geo_rst_q    <= 1'b1;
            geo_pt_q     <= '0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_err_q    <= 1'b0;
            res_id_q     <= '0;
            frame_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wdog_q       <= wdog_d;
            geo_rst_q    <= geo_rst_d;
            geo_pt_q     <= geo_pt_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_err_q    <= res_err_d;
            res_id_q     <= res_id_d;
            frame_id_q   <= frame_id_d;
        end
    end

    assign geo_rst    = geo_rst_q;
    assign geo_x      = geo_pt_q.x;
    assign geo_y      = geo_pt_q.y;
    assign res_valid  = res_valid_q;
    assign res_inside = res_inside_q;
    assign res_err    = res_err_q;
    assign res_id     = res_id_q;

endmodule

// File: doc/geofence_feeder.md
GEOFENCE_FEEDER -- requirements
Module: geofence_feeder

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 512: max cycles in WAIT before the frame is aborted.
REQ-002 SHALL have parameter ID_W, default 8: width of the frame counter.
REQ-003 SHALL have port clk, input, 1: single clock; all flops rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream point valid.
REQ-006 SHALL have port in_ready, output, 1: upstream point accepted when in_valid&&in_ready.
REQ-007 SHALL have port in_x, input, 10: upstream X; first point of a frame is the test object, points 2-7 are fence vertices.
REQ-008 SHALL have port in_y, input, 10: upstream Y.
REQ-009 SHALL have port geo_rst, output, 1: registered reset driven to the geofence evaluator.
REQ-010 SHALL have port geo_x, output, 10: registered X to the evaluator.
REQ-011 SHALL have port geo_y, output, 10: registered Y to the evaluator.
REQ-012 SHALL have port geo_valid, input, 1: evaluator done pulse.
REQ-013 SHALL have port geo_inside, input, 1: evaluator result; meaningful only while geo_valid=1.
REQ-014 SHALL have port res_valid, output, 1: one-cycle result pulse.
REQ-015 SHALL have port res_inside, output, 1: captured result.
REQ-016 SHALL have port res_err, output, 1: watchdog abort flag, qualified by res_valid.
REQ-017 SHALL have port res_id, output, ID_W: frame number of the result.

Function
REQ-018 SHALL buffer frames of 7 points in two banks (ping-pong), filled in arrival order at index 0..6.
REQ-019 SHALL drive in_ready=1 iff the current write bank is not full; the 7th accepted point SHALL mark that bank full and toggle the write bank.
REQ-020 SHALL implement FSM IDLE, STREAM, WAIT.
REQ-021 IDLE SHALL hold geo_rst=1; when the read bank is full it SHALL load point 0 into geo_x/geo_y, deassert geo_rst on the same edge and enter STREAM with idx=1.
REQ-022 STREAM SHALL present points 1..6 on the 6 following cycles with no gaps; the edge after point 6 is presented SHALL release the read bank (clear full, toggle read bank) and enter WAIT.
REQ-023 WAIT SHALL hold geo_x/geo_y and increment a watchdog counter each cycle.
REQ-024 On geo_valid=1 in WAIT: if the other bank is full, SHALL load its point 0 on that edge and enter STREAM (point 0 visible the cycle after geo_valid); otherwise SHALL set geo_rst=1 and enter IDLE.
REQ-025 On the edge where geo_valid is sampled, SHALL register res_valid=1, res_inside=geo_inside, res_err=0, res_id=frame counter, then increment the frame counter (wraps at 2^ID_W).
REQ-026 On watchdog reaching WDOG_CYCLES-1 without geo_valid, SHALL pulse res_valid with res_err=1 and res_inside=0, consume an id, set geo_rst=1 and enter IDLE.
REQ-027 geo_valid outside WAIT SHALL be ignored (no result, no state change).
REQ-028 A bank write completion and a bank release on the same edge SHALL both take effect.
REQ-029 A point SHALL take at least 1 cycle from acceptance to geo_x, and a bank SHALL never be read before it is full.

Reset
REQ-030 On reset: FSM=IDLE, geo_rst=1, geo_x=geo_y=0, both banks empty, write/read bank=0, write idx=0, watchdog=0, frame counter=0, res_valid=res_inside=res_err=0, res_id=0, in_ready=1 after reset deasserts.
REQ-031 Reset asserted mid-frame SHALL discard all buffered points and produce no result for in-flight frames.

Structure
REQ-032 Package geofence_pkg SHALL hold COORD_W=10, PTS_PER_FRAME=7, point struct {x,y}, FSM state enum.
REQ-033 Sub-module geofence_frame_buf SHALL contain the two 7-entry banks, write/read pointers, full flags and in_ready.

Verification
REQ-034 Bench SHALL cover: after reset, 7 points (500,500),(0,0),(1000,0),(1000,1000),(500,1020),(0,1000),(200,300) are pushed -> geo_rst falls, geo_x sequence 500,0,1000,1000,500,0,200 on 7 consecutive cycles.
REQ-035 Bench SHALL cover: two frames preloaded, then model pulses geo_valid with geo_inside=1 -> res_valid=1, res_inside=1, res_id=0, and geo_x of frame 2 point 0 on the next cycle while geo_rst stays 0.
REQ-036 Bench SHALL cover: 14 points pushed while frame 1 is in WAIT -> in_ready=0 after the 14th point until the bank is released.
REQ-037 Bench SHALL cover: no geo_valid for 512 cycles -> res_valid=1, res_err=1, geo_rst=1, FSM IDLE.
REQ-038 Bench SHALL cover: 256 frames -> res_id wraps 255->0.
REQ-039 Bench SHALL cover: reset during STREAM point 3 -> all outputs at reset values, no result emitted.
